// File: rtl/priority_encoder_83_pkg.sv
// Shared constants and types for the 8-to-3 priority encoder.
// The encoded width is derived from the request width so the two never drift.
package priority_encoder_83_pkg;

  localparam int PE_IN_W  = 8;
  localparam int PE_OUT_W = $clog2(PE_IN_W);

  typedef logic [PE_IN_W-1:0]  pe_req_t;
  typedef logic [PE_OUT_W-1:0] pe_idx_t;

  // Packed view of the registered result, handy for checkers: {valid, y}.
  typedef struct packed {
    logic    valid;
    pe_idx_t y;
  } pe_result_t;

endpackage

// File: rtl/priority_encoder_83_core.sv
// Combinational priority encoder: the highest-numbered set bit wins.
// Returns index 0 with any=0 when nothing is set; callers use any to tell
// "no request" apart from "request 0".
module priority_encoder_83_core #(
  parameter int IN_W  = 8,
  parameter int OUT_W = $clog2(IN_W)
) (
  input  logic [IN_W-1:0]  req,
  output logic [OUT_W-1:0] idx,
  output logic             any
);

  logic found;

  // MSB-first scan; the first set bit encountered from the top is latched in.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = IN_W - 1; i >= 0; i--) begin
      if (req[i] && !found) begin
        idx   = i[OUT_W-1:0];
        found = 1'b1;
      end
    end
    any = found;
  end

endmodule

// File: rtl/priority_encoder_83.sv
// 8-to-3 priority encoder with a single registered output stage.
// Latency is exactly one cycle: y/valid reflect val sampled on the previous
// rising edge. There is no enable and no handshake; the outputs update every
// cycle and come straight from flops. IN_W must be a power of two, >= 2.
module priority_encoder_83
  import priority_encoder_83_pkg::*;
#(
  parameter int IN_W = PE_IN_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IN_W-1:0]          val,
  output logic [$clog2(IN_W)-1:0]  y,
  output logic                     valid
);

  localparam int OUT_W = $clog2(IN_W);

  logic [OUT_W-1:0] enc_idx;
  logic             enc_any;

  priority_encoder_83_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .req (val),
    .idx (enc_idx),
    .any (enc_any)
  );

  // Output register; synchronous reset takes priority over the sampled request.
  always_ff @(posedge clk) begin
    if (rst) begin
      y     <= '0;
      valid <= 1'b0;
    end else begin
      y     <= enc_idx;
      valid <= enc_any;
    end
  end

endmodule

// File: tb/tb_priority_encoder_83.sv
// Directed and exhaustive bench for priority_encoder_83.
// Inputs are driven on the falling edge; the result for those inputs is
// checked on the following falling edge, after the capturing rising edge.
module tb_priority_encoder_83;

  logic       clk;
  logic       rst;
  logic [7:0] val;
  logic [2:0] y;
  logic       valid;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];
  string      tag_q[$];

  priority_encoder_83 dut (
    .clk   (clk),
    .rst   (rst),
    .val   (val),
    .y     (y),
    .valid (valid)
  );

  // Clock and initial input values.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst = 1'b1;
    val = 8'h00;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got valid,y=%b expected %b", tag, got, exp);
    end
  endtask

  // Reference: ascending scan keeping the last set bit seen.
  function automatic logic [3:0] model(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++)
      if (v[i]) idx = 3'(i);
    return {(v != 8'h00), idx};
  endfunction

  // One cycle: check the result due now, then apply new inputs and queue
  // the result expected one cycle later.
  task automatic drive(input string tag, input logic [7:0] v, input logic r,
                       input logic [3:0] exp);
    @(negedge clk);
    if (exp_q.size() > 0) check(tag_q.pop_front(), {valid, y}, exp_q.pop_front());
    val = v;
    rst = r;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic flush();
    @(negedge clk);
    if (exp_q.size() > 0) check(tag_q.pop_front(), {valid, y}, exp_q.pop_front());
  endtask

  initial begin
    logic [7:0] v;
    // Reset held two cycles with all requests high; reset wins.
    drive("rst_hold0", 8'hFF, 1'b1, 4'b0_000);
    drive("rst_hold1", 8'hFF, 1'b1, 4'b0_000);
    drive("rst_release", 8'hFF, 1'b0, 4'b1_111);
    // Zero versus bit 0.
    drive("zero", 8'b0000_0000, 1'b0, 4'b0_000);
    drive("bit0", 8'b0000_0001, 1'b0, 4'b1_000);
    // One-hot sweep.
    drive("onehot1", 8'b0000_0010, 1'b0, 4'b1_001);
    drive("onehot2", 8'b0000_0100, 1'b0, 4'b1_010);
    drive("onehot3", 8'b0000_1000, 1'b0, 4'b1_011);
    drive("onehot4", 8'b0001_0000, 1'b0, 4'b1_100);
    drive("onehot5", 8'b0010_0000, 1'b0, 4'b1_101);
    drive("onehot6", 8'b0100_0000, 1'b0, 4'b1_110);
    drive("onehot7", 8'b1000_0000, 1'b0, 4'b1_111);
    // Priority cases.
    drive("prio_ff", 8'b1111_1111, 1'b0, 4'b1_111);
    drive("prio_0a", 8'b0000_1010, 1'b0, 4'b1_011);
    drive("prio_2d", 8'b0010_1101, 1'b0, 4'b1_101);
    drive("prio_41", 8'b0100_0001, 1'b0, 4'b1_110);
    // Back-to-back changes every cycle.
    drive("b2b_80", 8'h80, 1'b0, 4'b1_111);
    drive("b2b_01", 8'h01, 1'b0, 4'b1_000);
    drive("b2b_00", 8'h00, 1'b0, 4'b0_000);
    drive("b2b_10", 8'h10, 1'b0, 4'b1_100);
    // Exhaustive against the model, with a mid-sequence reset.
    for (int i = 0; i < 256; i++) begin
      v = 8'(i);
      if (i == 100) drive("mid_rst", 8'hC3, 1'b1, 4'b0_000);
      drive($sformatf("exh_%02h", v), v, 1'b0, model(v));
    end
    flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
